// File: rtl/modos_ctrl.sv
// modos_ctrl: virtual-pet needs tracker (four 2-bit levels, hold strobes, periodic decay, fast test time base)
// Ports:
//   clk                                        system clock, rising edge
//   Bot_Reset                                  asynchronous active-high reset
//   Bot_Test                                   1 = fast time base (TEST_TICKS_PER_SEC)
//   Bot_Energia, Bot_Medicina                  hold buttons: +1 level and a strobe every HOLD_SEC held
//   Entrada_Descanso                           rest sensor: +1 Descanso every REST_SEC held
//   Entrada_Animo                              interaction sensor: +1 Animo per rising edge
//   LED_Animo/Energia/Descanso/Medicina        level registers 0..3
//   senal_5segEnergia, senal_5segMedicina      one-cycle hold strobes
// Define MODOS_INPUT_SYNC_EN to pass the level inputs through 2-FF synchronisers (+2 cycles latency).
module modos_ctrl #(
    parameter int TICKS_PER_SEC      = 50000000,
    parameter int TEST_TICKS_PER_SEC = 5,
    parameter int HOLD_SEC           = 5,
    parameter int REST_SEC           = 5,
    parameter int DECAY_SEC          = 30
) (
    input  logic       clk,
    input  logic       Bot_Reset,
    input  logic       Bot_Test,
    input  logic       Bot_Energia,
    input  logic       Bot_Medicina,
    input  logic       Entrada_Descanso,
    input  logic       Entrada_Animo,
    output logic [1:0] LED_Animo,
    output logic [1:0] LED_Energia,
    output logic [1:0] LED_Descanso,
    output logic [1:0] LED_Medicina,
    output logic       senal_5segMedicina,
    output logic       senal_5segEnergia
);
    localparam int MAX_PER = TICKS_PER_SEC > TEST_TICKS_PER_SEC ? TICKS_PER_SEC : TEST_TICKS_PER_SEC;
    localparam int TW = $clog2(MAX_PER + 1);
    localparam int HW = $clog2(HOLD_SEC + 1);
    localparam int RW = $clog2(REST_SEC + 1);
    localparam int DW = $clog2(DECAY_SEC + 1);

    logic [4:0] raw, in_s;
    logic       test, energia, medicina, descanso, animo;
    assign raw = {Bot_Test, Bot_Energia, Bot_Medicina, Entrada_Descanso, Entrada_Animo};
`ifdef MODOS_INPUT_SYNC_EN
    logic [4:0] sync1, sync2;
    always_ff @(posedge clk or posedge Bot_Reset)
        if (Bot_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    assign in_s = sync2;
`else
    assign in_s = raw;
`endif
    assign {test, energia, medicina, descanso, animo} = in_s;

    logic [TW-1:0] tick_cnt, period_m1;
    logic          test_q, sec_tick;
    assign period_m1 = test ? TW'(TEST_TICKS_PER_SEC - 1) : TW'(TICKS_PER_SEC - 1);
    // a mode change restarts the period, so the first tick in the new mode is a full period away
    assign sec_tick = test == test_q && tick_cnt == period_m1;

    always_ff @(posedge clk or posedge Bot_Reset)
        if (Bot_Reset) begin
            tick_cnt <= '0;
            test_q   <= 1'b0;
        end else begin
            tick_cnt <= (test != test_q || sec_tick) ? '0 : tick_cnt + TW'(1);
            test_q   <= test;
        end

    logic [HW-1:0] en_cnt, med_cnt;
    logic [RW-1:0] rest_cnt;
    logic [DW-1:0] decay_cnt;
    logic          animo_q, en_fire, med_fire, rest_fire, decay, animo_edge;
    // fire on the tick that completes the hold; the counter restarts so a long hold repeats
    assign en_fire    = energia  && sec_tick && en_cnt   == HW'(HOLD_SEC - 1);
    assign med_fire   = medicina && sec_tick && med_cnt  == HW'(HOLD_SEC - 1);
    assign rest_fire  = descanso && sec_tick && rest_cnt == RW'(REST_SEC - 1);
    assign decay      = sec_tick && decay_cnt == DW'(DECAY_SEC - 1);
    assign animo_edge = animo && !animo_q;

    // saturating +1/-1; simultaneous increment and decay cancel
    function automatic logic [1:0] step(input logic [1:0] lvl, input logic inc, input logic dec);
        return (inc && !dec && lvl != 2'd3) ? lvl + 2'd1 :
               (dec && !inc && lvl != 2'd0) ? lvl - 2'd1 : lvl;
    endfunction

    always_ff @(posedge clk or posedge Bot_Reset)
        if (Bot_Reset) begin
            en_cnt             <= '0;
            med_cnt            <= '0;
            rest_cnt           <= '0;
            decay_cnt          <= '0;
            animo_q            <= 1'b0;
            senal_5segEnergia  <= 1'b0;
            senal_5segMedicina <= 1'b0;
            LED_Animo          <= 2'd3;
            LED_Energia        <= 2'd3;
            LED_Descanso       <= 2'd3;
            LED_Medicina       <= 2'd3;
        end else begin
            en_cnt             <= (!energia || en_fire) ? '0 : en_cnt + HW'(sec_tick);
            med_cnt            <= (!medicina || med_fire) ? '0 : med_cnt + HW'(sec_tick);
            rest_cnt           <= (!descanso || rest_fire) ? '0 : rest_cnt + RW'(sec_tick);
            decay_cnt          <= decay ? '0 : decay_cnt + DW'(sec_tick);
            animo_q            <= animo;
            senal_5segEnergia  <= en_fire;
            senal_5segMedicina <= med_fire;
            LED_Animo          <= step(LED_Animo, animo_edge, decay);
            LED_Energia        <= step(LED_Energia, en_fire, decay);
            LED_Descanso       <= step(LED_Descanso, rest_fire, decay);
            LED_Medicina       <= step(LED_Medicina, med_fire, decay);
        end
endmodule

// File: tb/tb_modos_ctrl.sv
// tb_modos_ctrl: scenario tasks plus randomized traffic against a seconds-based reference model
module tb_modos_ctrl;
    localparam int TP = 20, TT = 5, HS = 5, RS = 5, DS = 3;

    logic       clk = 0, Bot_Reset = 0, Bot_Test = 0, Bot_Energia = 0, Bot_Medicina = 0;
    logic       Entrada_Descanso = 0, Entrada_Animo = 0;
    logic [1:0] LED_Animo, LED_Energia, LED_Descanso, LED_Medicina;
    logic       senal_5segMedicina, senal_5segEnergia;
    int         checks = 0, passes = 0;

    always #5 clk = ~clk;

    modos_ctrl #(.TICKS_PER_SEC(TP), .TEST_TICKS_PER_SEC(TT), .HOLD_SEC(HS), .REST_SEC(RS), .DECAY_SEC(DS)) dut (
        .clk(clk), .Bot_Reset(Bot_Reset), .Bot_Test(Bot_Test), .Bot_Energia(Bot_Energia),
        .Bot_Medicina(Bot_Medicina), .Entrada_Descanso(Entrada_Descanso), .Entrada_Animo(Entrada_Animo),
        .LED_Animo(LED_Animo), .LED_Energia(LED_Energia), .LED_Descanso(LED_Descanso),
        .LED_Medicina(LED_Medicina), .senal_5segMedicina(senal_5segMedicina), .senal_5segEnergia(senal_5segEnergia)
    );

    // reference model: elapsed cycles, total seconds and held seconds; events fire on multiples
    logic [4:0] raw, mi;
    assign raw = {Bot_Test, Bot_Energia, Bot_Medicina, Entrada_Descanso, Entrada_Animo};
`ifdef MODOS_INPUT_SYNC_EN
    logic [4:0] s1, s2;
    always @(posedge clk or posedge Bot_Reset)
        if (Bot_Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    assign mi = s2;
`else
    assign mi = raw;
`endif
    int       m_el, m_ticks, m_held[3], m_lvl[4];
    bit       m_tp, m_ap, tick, dec;
    bit [1:0] m_stb;
    bit [2:0] fire;
    bit [3:0] inc;
    logic [9:0] dut_out, m_out;
    assign dut_out = {LED_Animo, LED_Energia, LED_Descanso, LED_Medicina, senal_5segMedicina, senal_5segEnergia};
    assign m_out = {2'(m_lvl[0]), 2'(m_lvl[1]), 2'(m_lvl[2]), 2'(m_lvl[3]), m_stb[1], m_stb[0]};

    task automatic model_reset();
        m_el = 0; m_ticks = 0; m_tp = 0; m_ap = 0; m_stb = 0;
        for (int k = 0; k < 3; k++) m_held[k] = 0;
        for (int k = 0; k < 4; k++) m_lvl[k] = 3;
    endtask

    task automatic model_step();
        tick = 0;
        if (mi[4] != m_tp) m_el = 0;
        else begin
            m_el++;
            tick = (m_el % (mi[4] ? TT : TP)) == 0;
        end
        m_tp = mi[4];
        if (tick) m_ticks++;
        dec = tick && (m_ticks % DS) == 0;
        for (int k = 0; k < 3; k++) begin
            if (!mi[3-k]) m_held[k] = 0;
            else if (tick) m_held[k]++;
            fire[k] = mi[3-k] && tick && (m_held[k] % (k == 2 ? RS : HS)) == 0;
        end
        inc = {fire[1], fire[2], fire[0], mi[0] && !m_ap};
        m_ap = mi[0];
        for (int k = 0; k < 4; k++)
            if (inc[k] && !dec) m_lvl[k] = m_lvl[k] < 3 ? m_lvl[k] + 1 : 3;
            else if (dec && !inc[k]) m_lvl[k] = m_lvl[k] > 0 ? m_lvl[k] - 1 : 0;
        m_stb = {fire[1], fire[0]};
    endtask

    always @(posedge clk or posedge Bot_Reset)
        if (Bot_Reset) model_reset();
        else model_step();

    function automatic bit next_tick();
        return mi[4] == m_tp && ((m_el + 1) % (mi[4] ? TT : TP)) == 0;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        Bot_Reset = 1;
        @(negedge clk);
        Bot_Reset = 0;
    endtask

    task automatic test_reset();
        #1 Bot_Reset = 1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (dut_out !== 10'b1111111100) $display("FAIL reset_hold got=%b want=%b", dut_out, 10'b1111111100); else passes++;
        end
        Bot_Reset = 0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (dut_out !== m_out) $display("FAIL reset_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        Bot_Test = 1;
        pulse_reset();
        while (m_lvl[1] != 1 && n < 100) begin
            @(negedge clk);
            n++;
            checks++; if (dut_out !== m_out) $display("FAIL areset_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
        checks++; if (LED_Energia !== 2'd1) $display("FAIL areset_pre got=%0d want=1", LED_Energia); else passes++;
        #2 Bot_Reset = 1;
        #1;
        checks++; if (dut_out !== 10'b1111111100) $display("FAIL areset_async got=%b want=%b", dut_out, 10'b1111111100); else passes++;
        repeat (3) begin
            @(negedge clk);
            checks++; if (dut_out !== 10'b1111111100) $display("FAIL areset_held got=%b want=%b", dut_out, 10'b1111111100); else passes++;
        end
        Bot_Reset = 0;
    endtask

    task automatic test_decay();
        int e;
        Bot_Test = 1;
        pulse_reset();
        repeat (60) begin
            @(negedge clk);
            e = m_ticks / DS >= 3 ? 0 : 3 - m_ticks / DS;
            checks++; if (dut_out !== m_out) $display("FAIL decay_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
            checks++; if (LED_Animo !== 2'(e) || LED_Medicina !== 2'(e)) $display("FAIL decay_sched ticks=%0d got=%0d/%0d want=%0d", m_ticks, LED_Animo, LED_Medicina, e); else passes++;
        end
        checks++; if (dut_out[9:2] !== 8'd0) $display("FAIL decay_floor got=%b want=00000000", dut_out[9:2]); else passes++;
    endtask

    task automatic test_animo();
        Bot_Test = 0;
        checks++; if (LED_Animo !== 2'd0) $display("FAIL animo_start got=%0d want=0", LED_Animo); else passes++;
        Entrada_Animo = 1;
        repeat (6) begin
            @(negedge clk);
            checks++; if (LED_Animo !== 2'd1) $display("FAIL animo_long_high got=%0d want=1", LED_Animo); else passes++;
        end
        Entrada_Animo = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            Entrada_Animo = 1;
            @(negedge clk);
            checks++; if (LED_Animo !== (i == 0 ? 2'd2 : 2'd3)) $display("FAIL animo_pulse%0d got=%0d want=%0d", i, LED_Animo, i == 0 ? 2 : 3); else passes++;
            Entrada_Animo = 0;
            @(negedge clk);
            checks++; if (dut_out !== m_out) $display("FAIL animo_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
    endtask

    task automatic test_collision();
        int n = 0;
        Bot_Test = 1;
        while (m_lvl[0] != 2 && n < 200) begin
            @(negedge clk);
            n++;
            checks++; if (dut_out !== m_out) $display("FAIL coll_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
        n = 0;
        while (!(next_tick() && ((m_ticks + 1) % DS) == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 50 || LED_Animo !== 2'd2) $display("FAIL coll_setup waited=%0d animo=%0d want=2", n, LED_Animo); else passes++;
        Entrada_Animo = 1;
        @(negedge clk);
        checks++; if (LED_Animo !== 2'd2) $display("FAIL collision got=%0d want=2", LED_Animo); else passes++;
        checks++; if (dut_out !== m_out) $display("FAIL coll_model2 t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        Entrada_Animo = 0;
    endtask

    task automatic test_energia_hold();
        int n = 0, pulses = 0;
        pulse_reset();
        while (m_lvl[1] != 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (LED_Energia !== 2'd2) $display("FAIL energia_preset got=%0d want=2", LED_Energia); else passes++;
        Bot_Energia = 1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            pulses += int'(senal_5segEnergia);
            checks++; if (dut_out !== m_out) $display("FAIL energia_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
            if (i == 25) begin
                checks++; if (pulses != 1 || LED_Energia !== 2'd2 || LED_Animo !== 2'd1) $display("FAIL energia_first pulses=%0d en=%0d an=%0d want 1/2/1", pulses, LED_Energia, LED_Animo); else passes++;
            end
        end
        checks++; if (pulses != 2 || LED_Energia !== 2'd1 || LED_Animo !== 2'd0) $display("FAIL energia_second pulses=%0d en=%0d an=%0d want 2/1/0", pulses, LED_Energia, LED_Animo); else passes++;
        Bot_Energia = 0;
    endtask

    task automatic test_short_press();
        int n = 0, pulses = 0;
        Bot_Medicina = 1;
        @(negedge clk);
        while (!(m_held[1] == HS - 1 && next_tick()) && n < 60) begin
            @(negedge clk);
            n++;
        end
        Bot_Medicina = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(senal_5segMedicina);
        end
        checks++; if (n >= 60 || pulses != 0) $display("FAIL med_early_release pulses=%0d want=0", pulses); else passes++;
        Bot_Medicina = 1;
        repeat (8) begin @(negedge clk); pulses += int'(senal_5segMedicina); end
        Bot_Medicina = 0;
        repeat (2) begin @(negedge clk); pulses += int'(senal_5segMedicina); end
        Bot_Medicina = 1;
        repeat (20) begin
            @(negedge clk);
            pulses += int'(senal_5segMedicina);
            checks++; if (dut_out !== m_out) $display("FAIL med_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
        checks++; if (pulses != 0) $display("FAIL med_short pulses=%0d want=0", pulses); else passes++;
        repeat (5) begin @(negedge clk); pulses += int'(senal_5segMedicina); end
        checks++; if (pulses != 1) $display("FAIL med_fifth_tick pulses=%0d want=1", pulses); else passes++;
        Bot_Medicina = 0;
    endtask

    task automatic test_descanso();
        int n = 0;
        pulse_reset();
        while (m_lvl[2] != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        Entrada_Descanso = 1;
        repeat (25) begin
            @(negedge clk);
            checks++; if (dut_out !== m_out) $display("FAIL rest_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
        end
        checks++; if (LED_Descanso !== 2'd1 || LED_Animo !== 2'd0) $display("FAIL rest_incr des=%0d an=%0d want 1/0", LED_Descanso, LED_Animo); else passes++;
        Entrada_Descanso = 0;
    endtask

    task automatic test_random();
        pulse_reset();
        repeat (400) begin
            @(negedge clk);
            checks++; if (dut_out !== m_out) $display("FAIL random_model t=%0t got=%b want=%b", $time, dut_out, m_out); else passes++;
            if ($urandom_range(0, 39) == 0) Bot_Test = ~Bot_Test;
            if ($urandom_range(0, 5) == 0) Bot_Energia = ~Bot_Energia;
            if ($urandom_range(0, 5) == 0) Bot_Medicina = ~Bot_Medicina;
            if ($urandom_range(0, 5) == 0) Entrada_Descanso = ~Entrada_Descanso;
            if ($urandom_range(0, 3) == 0) Entrada_Animo = ~Entrada_Animo;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_async_reset();
        test_decay();
        test_animo();
        test_collision();
        test_energia_hold();
        test_short_press();
        test_descanso();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
